dco_multi_channel: RTL and testbench

- Parametrised successor to the single-channel frequency divider/DCO: CH independent oscillator channels, each with N-bit period and duty, a start-phase offset and an optional burst length.
- Configuration goes through a shared write port into per-channel shadow registers. Shadows become active only at a period boundary, so waveforms never glitch.
- Drives neuron resonance/spike timing across several neuron lanes from one system clock.

---
 rtl/dco_pkg.sv | 21 ++
 rtl/dco_channel.sv | 112 +++++++++++
 rtl/dco_multi_channel.sv | 51 +++++
 tb/tb_dco_multi_channel.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared definitions for the multi-channel DCO: channel state encoding,
// default widths and the default-width configuration record.
package dco_pkg;

  localparam int N_DEF  = 8;
  localparam int CH_DEF = 4;
  localparam int BW_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dco_state_e;

  typedef struct packed {
    logic [N_DEF-1:0]  max;
    logic [N_DEF-1:0]  duty;
    logic [N_DEF-1:0]  phase;
    logic [BW_DEF-1:0] burst;
  } dco_cfg_t;

endpackage

// File: rtl/dco_channel.sv
// One oscillator channel: shadow/active configuration, period counter,
// burst counter and IDLE/RUN control with osc/wrap/done decode.
module dco_channel
  import dco_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we_i,
  input  logic [N-1:0]  cfg_max_i,
  input  logic [N-1:0]  cfg_duty_i,
  input  logic [N-1:0]  cfg_phase_i,
  input  logic [BW-1:0] cfg_burst_i,
  input  logic          en_i,
  output logic          osc_o,
  output logic          wrap_o,
  output logic          done_o,
  output logic          busy_o
);

  typedef struct packed {
    logic [N-1:0]  max;
    logic [N-1:0]  duty;
    logic [N-1:0]  phase;
    logic [BW-1:0] burst;
  } cfg_t;

  dco_state_e    state_q, state_d;
  cfg_t          sh_q, sh_d, sh_eff;
  logic [N-1:0]  act_max_q, act_max_d;
  logic [N-1:0]  act_duty_q, act_duty_d;
  logic [BW-1:0] act_burst_q, act_burst_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [BW-1:0] pcnt_q, pcnt_d;
  logic          en_d_q;
  logic          run, last;

  always_comb begin
    // A write landing on the same edge as a start or wrap is seen immediately.
    sh_eff = cfg_we_i ? cfg_t'{cfg_max_i, cfg_duty_i, cfg_phase_i, cfg_burst_i} : sh_q;
    sh_d   = sh_eff;

    run    = (state_q == ST_RUN);
    wrap_o = run && (cnt_q == act_max_q);
    last   = wrap_o && (act_burst_q != '0) &&
             (({1'b0, pcnt_q} + (BW+1)'(1)) == {1'b0, act_burst_q});
    done_o = last;
    osc_o  = run && (cnt_q < act_duty_q);
    busy_o = run;

    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    act_max_d   = act_max_q;
    act_duty_d  = act_duty_q;
    act_burst_d = act_burst_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i && !en_d_q) begin
          state_d     = ST_RUN;
          act_max_d   = sh_eff.max;
          act_duty_d  = sh_eff.duty;
          act_burst_d = sh_eff.burst;
          cnt_d       = (sh_eff.phase <= sh_eff.max) ? sh_eff.phase : '0;
          pcnt_d      = '0;
        end
      end
      ST_RUN: begin
        if (!en_i || last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pcnt_d  = '0;
        end else if (wrap_o) begin
          cnt_d       = '0;
          act_max_d   = sh_eff.max;
          act_duty_d  = sh_eff.duty;
          act_burst_d = sh_eff.burst;
          pcnt_d      = (pcnt_q == '1) ? pcnt_q : pcnt_q + BW'(1);
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      act_max_q   <= '0;
      act_duty_q  <= '0;
      act_burst_q <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      en_d_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      act_max_q   <= act_max_d;
      act_duty_q  <= act_duty_d;
      act_burst_q <= act_burst_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      en_d_q      <= en_i;
    end
  end

endmodule

// File: rtl/dco_multi_channel.sv
// CH independent DCO channels sharing one configuration write port;
// the write is steered to the addressed channel's shadow registers.
module dco_multi_channel
  import dco_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CH = CH_DEF,
  parameter int BW = BW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [$clog2(CH)-1:0] cfg_ch,
  input  logic [N-1:0]          cfg_max,
  input  logic [N-1:0]          cfg_duty,
  input  logic [N-1:0]          cfg_phase,
  input  logic [BW-1:0]         cfg_burst,
  input  logic [CH-1:0]         en,
  output logic [CH-1:0]         osc,
  output logic [CH-1:0]         wrap,
  output logic [CH-1:0]         done,
  output logic [CH-1:0]         busy
);

  localparam int CHW = $clog2(CH);

  // Addresses at or above CH match no channel and are dropped.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic we_c;
    assign we_c = cfg_we && (cfg_ch == CHW'(c));

    dco_channel #(
      .N  (N),
      .BW (BW)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .cfg_we_i    (we_c),
      .cfg_max_i   (cfg_max),
      .cfg_duty_i  (cfg_duty),
      .cfg_phase_i (cfg_phase),
      .cfg_burst_i (cfg_burst),
      .en_i        (en[c]),
      .osc_o       (osc[c]),
      .wrap_o      (wrap[c]),
      .done_o      (done[c]),
      .busy_o      (busy[c])
    );
  end

endmodule

// File: tb/tb_dco_multi_channel.sv
// Bench for dco_multi_channel: directed scenarios with literal expectations,
// then random traffic against a per-channel behavioural model.
module tb_dco_multi_channel;

  localparam int N  = 8;
  localparam int CH = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [N-1:0]  cfg_max, cfg_duty, cfg_phase;
  logic [BW-1:0] cfg_burst;
  logic [CH-1:0] en;
  logic [CH-1:0] osc, wrap, done, busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state, one entry per channel.
  int m_run[CH], m_cnt[CH], m_pcnt[CH], m_en_d[CH];
  int sh_max[CH], sh_duty[CH], sh_phase[CH], sh_burst[CH];
  int a_max[CH], a_duty[CH], a_burst[CH];

  always #5 clk = ~clk;

  dco_multi_channel #(.N(N), .CH(CH), .BW(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_max   (cfg_max),
    .cfg_duty  (cfg_duty),
    .cfg_phase (cfg_phase),
    .cfg_burst (cfg_burst),
    .en        (en),
    .osc       (osc),
    .wrap      (wrap),
    .done      (done),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int m_wrap(input int c);
    return (m_run[c] != 0 && m_cnt[c] == a_max[c]) ? 1 : 0;
  endfunction

  function automatic int m_done(input int c);
    return (m_wrap(c) != 0 && a_burst[c] != 0 && m_pcnt[c] + 1 == a_burst[c]) ? 1 : 0;
  endfunction

  function automatic int m_osc(input int c);
    return (m_run[c] != 0 && m_cnt[c] < a_duty[c]) ? 1 : 0;
  endfunction

  task automatic model_step();
    int e_max, e_duty, e_phase, e_burst, w, fin;
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        m_run[c] = 0; m_cnt[c] = 0; m_pcnt[c] = 0; m_en_d[c] = 0;
        sh_max[c] = 0; sh_duty[c] = 0; sh_phase[c] = 0; sh_burst[c] = 0;
        a_max[c] = 0; a_duty[c] = 0; a_burst[c] = 0;
      end else begin
        if (cfg_we && int'(cfg_ch) == c) begin
          e_max = int'(cfg_max); e_duty = int'(cfg_duty);
          e_phase = int'(cfg_phase); e_burst = int'(cfg_burst);
        end else begin
          e_max = sh_max[c]; e_duty = sh_duty[c];
          e_phase = sh_phase[c]; e_burst = sh_burst[c];
        end
        w   = m_wrap(c);
        fin = m_done(c);
        if (m_run[c] == 0) begin
          if (en[c] && m_en_d[c] == 0) begin
            m_run[c] = 1;
            a_max[c] = e_max; a_duty[c] = e_duty; a_burst[c] = e_burst;
            m_cnt[c] = (e_phase <= e_max) ? e_phase : 0;
            m_pcnt[c] = 0;
          end
        end else if (!en[c] || fin != 0) begin
          m_run[c] = 0; m_cnt[c] = 0; m_pcnt[c] = 0;
        end else if (w != 0) begin
          m_cnt[c] = 0;
          a_max[c] = e_max; a_duty[c] = e_duty; a_burst[c] = e_burst;
          m_pcnt[c] = (m_pcnt[c] >= 255) ? 255 : m_pcnt[c] + 1;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        m_en_d[c] = en[c] ? 1 : 0;
        sh_max[c] = e_max; sh_duty[c] = e_duty; sh_phase[c] = e_phase; sh_burst[c] = e_burst;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("osc%0d", c),  32'(osc[c]),  32'(m_osc(c)));
        check($sformatf("wrap%0d", c), 32'(wrap[c]), 32'(m_wrap(c)));
        check($sformatf("done%0d", c), 32'(done[c]), 32'(m_done(c)));
        check($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_run[c]));
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int mx, input int dt, input int ph, input int bu);
    cfg_we = 1'b1; cfg_ch = 2'(ch);
    cfg_max = N'(mx); cfg_duty = N'(dt); cfg_phase = N'(ph); cfg_burst = BW'(bu);
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    int pat_a[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int pat_g[6] = '{0, 0, 1, 0, 0, 0};
    int pat_p[6] = '{0, 0, 1, 1, 0, 0};
    int pat_b[6] = '{1, 0, 1, 0, 1, 0};

    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0; cfg_duty = '0;
    cfg_phase = '0; cfg_burst = '0; en = '0;
    cycle();
    cycle();
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_outs", {osc, wrap, done, busy}, 32'd0);

    // Continuous run on ch0.
    cfg_write(0, 3, 2, 0, 0);
    en[0] = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      check("lit_osc0", 32'(osc[0]), 32'(pat_a[i]));
      check("lit_wrap0", 32'(wrap[0]), (i % 4 == 3) ? 32'd1 : 32'd0);
      cycle();
    end
    // Duty change written at cnt=1 takes effect only at the next period.
    cycle();
    cfg_write(0, 3, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check("lit_glitch0", 32'(osc[0]), 32'(pat_g[i]));
      cycle();
    end

    // Phase offset, then out-of-range phase clamps to 0.
    cfg_write(1, 3, 2, 2, 0);
    en[1] = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      check("lit_phase1", 32'(osc[1]), 32'(pat_p[i]));
      cycle();
    end
    en[1] = 1'b0;
    cfg_write(1, 3, 2, 7, 0);
    en[1] = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("lit_clamp1", 32'(osc[1]), 32'(pat_a[i]));
      cycle();
    end

    // Burst of three periods on ch2.
    cfg_write(2, 1, 1, 0, 3);
    en[2] = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      check("lit_burst2", 32'(osc[2]), 32'(pat_b[i]));
      check("lit_done2", 32'(done[2]), (i == 5) ? 32'd1 : 32'd0);
      cycle();
    end
    cycle();
    check("lit_noretrig2", 32'(busy[2]), 32'd0);
    en[2] = 1'b0;
    cycle();
    en[2] = 1'b1;
    cycle();
    check("lit_restart2", 32'(busy[2]), 32'd1);

    // Extremes on ch3, then abort mid-period.
    cfg_write(3, 2, 5, 0, 0);
    en[3] = 1'b1;
    repeat (7) cycle();
    check("lit_const1", 32'(osc[3]), 32'd1);
    en[3] = 1'b0;
    cycle();
    check("lit_abort3", 32'({osc[3], done[3], busy[3]}), 32'd0);
    cfg_write(3, 0, 1, 0, 0);
    en[3] = 1'b1;
    repeat (3) cycle();
    check("lit_max0_wrap", 32'({osc[3], wrap[3]}), 32'd3);
    en[3] = 1'b0;
    cfg_write(3, 4, 0, 0, 0);
    en[3] = 1'b1;
    repeat (3) cycle();

    // Reset mid-run; restart with cleared shadows.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("lit_reset_run", 32'({osc, wrap, done, busy}), 32'd0);
    cycle();
    check("lit_restart_blank", 32'({osc[0], wrap[0]}), 32'd1);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_max   = ($urandom_range(0, 15) == 0) ? N'($urandom) : N'($urandom_range(0, 6));
      cfg_duty  = N'($urandom_range(0, 8));
      cfg_phase = N'($urandom_range(0, 8));
      cfg_burst = BW'($urandom_range(0, 4));
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
      reset = ($urandom_range(0, 599) == 0);
      cycle();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
